// File: rtl/cla_chunk_add_ctrl_pkg.sv
// Shared types and constants for the chunked CLA add/subtract controller.
package cla_chunk_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_WORDS = 4;

  // Chunk index width; at least one bit so the index register always exists.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 2) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla_chunk_add_ctrl_if.sv
// Request/result bundle between the operand front end and the controller.
interface cla_chunk_add_ctrl_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = N * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, a_in, b_in,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a_in, b_in,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/cla_slice.sv
// Combinational N-bit carry-lookahead slice built from generate/propagate terms.
module cla_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   c;

  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    sum  = prop ^ c[N-1:0];
    cout = c[N];
  end

endmodule

// File: rtl/cla_chunk_add_ctrl.sv
// Sequences one N-bit CLA slice over WORDS chunks, LSB chunk first, for wide add/sub.
module cla_chunk_add_ctrl
  import cla_chunk_add_ctrl_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_chunk_add_ctrl_if.slave  bus
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned IW = idx_width(WORDS);

  state_t                    state;
  logic [IW-1:0]             idx;
  logic                      carry_q;
  logic [WORDS-1:0][N-1:0]   a_q;
  logic [WORDS-1:0][N-1:0]   b_q;
  logic [WORDS-1:0][N-1:0]   sum_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      cout_q;
  logic                      ovf_q;

  logic [N-1:0]              s_sum;
  logic                      s_cout;

  cla_slice #(.N(N)) u_slice (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // FSM, chunk sequencing and result assembly; b is pre-inverted so sub reuses the adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in ^ {W{bus.sub}};
            carry_q <= (bus.sub == OP_SUB);
            idx     <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= s_sum;
          carry_q    <= s_cout;
          if (idx == IW'(WORDS - 1)) begin
            cout_q <= s_cout;
            ovf_q  <= (a_q[WORDS-1][N-1] ~^ b_q[WORDS-1][N-1])
                    & (a_q[WORDS-1][N-1] ^ s_sum[N-1]);
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_cla_chunk_add_ctrl.sv
// Directed-vector bench for cla_chunk_add_ctrl with default N=4, WORDS=4.
module tb_cla_chunk_add_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   done_cnt;

  cla_chunk_add_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

  cla_chunk_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done is sampled at the rising edge that ends its cycle
  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Steps edge by edge until done is seen at a negedge; returns edge count (20 on timeout).
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (bus.done !== 1'b1 && k < 20);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
    int k;
    int c0;
    c0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.sub = s;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a_in = 16'hDEAD; bus.b_in = 16'hBEEF; bus.sub = ~s;
    check_val({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
    check_val({tag, ".sum_clr"}, 32'(bus.sum), 32'd0);
    wait_done(k);
    check_val({tag, ".latency"}, 32'(k), 32'(WORDS));
    check_val({tag, ".sum"}, 32'(bus.sum), 32'(es));
    check_val({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    check_val({tag, ".ovf"}, 32'(bus.overflow), 32'(eo));
    check_val({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, ".done_low"}, 32'(bus.done), 32'd0);
    check_val({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
    check_val({tag, ".sum_hold"}, 32'(bus.sum), 32'(es));
    check_val({tag, ".pulses"}, 32'(done_cnt - c0), 32'd1);
  endtask

  initial begin
    int k;
    int c0;
    n_checks = 0; n_errors = 0; done_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a_in = '0; bus.b_in = '0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("rst.busy", 32'(bus.busy), 32'd0);
      check_val("rst.done", 32'(bus.done), 32'd0);
      check_val("rst.sum", 32'(bus.sum), 32'd0);
      check_val("rst.cout", 32'(bus.cout), 32'd0);
      check_val("rst.ovf", 32'(bus.overflow), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle.busy", 32'(bus.busy), 32'd0);
    check_val("idle.done", 32'(bus.done), 32'd0);
    check_val("idle.sum", 32'(bus.sum), 32'd0);

    run_op("add_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_plain", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_nobrw", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed during RUN and during DONE is ignored; start on the following edge is taken
    c0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 16'h1234; bus.b_in = 16'h4321; bus.sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.a_in = 16'hFFFF; bus.b_in = 16'hFFFF; bus.sub = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    check_val("busy_ign.latency", 32'(k), 32'(WORDS - 1));
    check_val("busy_ign.sum", 32'(bus.sum), 32'h5555);
    check_val("busy_ign.cout", 32'(bus.cout), 32'd0);
    bus.start = 1'b1; bus.a_in = 16'h0007; bus.b_in = 16'h0005; bus.sub = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("busy_ign.idle_busy", 32'(bus.busy), 32'd0);
    check_val("busy_ign.idle_done", 32'(bus.done), 32'd0);
    check_val("busy_ign.held", 32'(bus.sum), 32'h5555);
    check_val("busy_ign.pulses", 32'(done_cnt - c0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_val("next_acc.busy", 32'(bus.busy), 32'd1);
    check_val("next_acc.sum_clr", 32'(bus.sum), 32'd0);
    wait_done(k);
    check_val("next_acc.latency", 32'(k), 32'(WORDS));
    check_val("next_acc.sum", 32'(bus.sum), 32'h0002);
    check_val("next_acc.cout", 32'(bus.cout), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_val("next_acc.pulses", 32'(done_cnt - c0), 32'd2);

    // reset on the second RUN cycle discards the partial sum with no done pulse
    c0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 16'h1111; bus.b_in = 16'h1111; bus.sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst.partial", 32'(bus.sum), 32'h0002);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst.busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst.sum", 32'(bus.sum), 32'd0);
    check_val("mid_rst.cout", 32'(bus.cout), 32'd0);
    repeat (6) @(negedge clk);
    check_val("mid_rst.no_done", 32'(done_cnt - c0), 32'd0);
    check_val("mid_rst.still_idle", 32'(bus.busy), 32'd0);
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
